// File: rtl/spybuffer_event_reader.sv
// spybuffer_event_reader
// Drains the input spy buffer through its FIFO read port (1-cycle read
// latency) and re-presents the words as a valid/ready stream. A two-state
// framing tracker tags headers (sop) and footers (eop), drops words that
// arrive outside an event, flags oversize events and keeps saturating
// event/drop statistics.
module spybuffer_event_reader #(
    parameter int SIZE            = 65,
    parameter int MAX_EVENT_WORDS = 1024,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fifo_empty,
    output logic                 fifo_read_enable,
    input  logic [SIZE-1:0]      fifo_read_data,
    output logic [SIZE-1:0]      out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic [CNT_WIDTH-1:0] event_count,
    output logic [CNT_WIDTH-1:0] dropped_count,
    output logic                 framing_error,
    output logic                 overflow_error
);

    // Word counter must reach MAX_EVENT_WORDS+1 so the overflow transition is seen.
    localparam int              WC_W   = $clog2(MAX_EVENT_WORDS + 2);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_EVENT_WORDS);
    localparam logic [WC_W-1:0] WC_SAT = WC_W'(MAX_EVENT_WORDS + 1);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_IN_EVENT = 1'b1
    } state_t;

    // Framing state
    state_t          r_state;
    state_t          w_state_next;
    logic [WC_W-1:0] r_word_cnt;
    logic [WC_W-1:0] w_word_cnt_next;

    // Read side / skid buffer control
    logic            r_inflight;
    logic [1:0]      r_occ;
    logic            r_head;
    logic            w_wr_idx;
    logic            w_pop;
    logic            w_valid;

    // Skid buffer storage (datapath, not reset; qualified by occupancy)
    logic [SIZE-1:0] r_buf_data [2];
    logic            r_buf_sop  [2];
    logic            r_buf_eop  [2];

    // Capture-time decisions
    logic            w_flag;
    logic            w_enq;
    logic            w_enq_sop;
    logic            w_enq_eop;
    logic            w_drop;
    logic            w_ovf;

    // Statistics and pulses
    logic [CNT_WIDTH-1:0] r_event_count;
    logic [CNT_WIDTH-1:0] r_dropped_count;
    logic                 r_framing_error;
    logic                 r_overflow_error;

    // Saturating increment: counters stick at all-ones rather than wrap.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_valid = (r_occ != 2'd0);
    assign w_pop   = w_valid & out_ready;
    assign w_flag  = fifo_read_data[SIZE-1];

    // Issue a read only if the word it returns is guaranteed a slot: buffered
    // words plus the outstanding read, minus what leaves this cycle, must be < 2.
    // Held low during reset so nothing is pulled from the spy buffer.
    assign fifo_read_enable = !reset && !fifo_empty &&
                              (({1'b0, r_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));

    // Next free slot sits one past the head when one word is held; when the
    // held word is popped in the same cycle that slot is still free.
    assign w_wr_idx = r_head ^ r_occ[0];

    assign out_valid      = w_valid;
    assign out_data       = w_valid ? r_buf_data[r_head] : '0;
    assign out_sop        = w_valid ? r_buf_sop[r_head]  : 1'b0;
    assign out_eop        = w_valid ? r_buf_eop[r_head]  : 1'b0;
    assign event_count    = r_event_count;
    assign dropped_count  = r_dropped_count;
    assign framing_error  = r_framing_error;
    assign overflow_error = r_overflow_error;

    // Framing decision for the word returning from the FIFO this cycle.
    always_comb begin
        w_state_next    = r_state;
        w_word_cnt_next = r_word_cnt;
        w_enq           = 1'b0;
        w_enq_sop       = 1'b0;
        w_enq_eop       = 1'b0;
        w_drop          = 1'b0;
        w_ovf           = 1'b0;
        if (r_inflight) begin
            case (r_state)
                S_IDLE: begin
                    if (w_flag) begin
                        w_enq           = 1'b1;
                        w_enq_sop       = 1'b1;
                        w_word_cnt_next = '0;
                        w_state_next    = S_IN_EVENT;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                S_IN_EVENT: begin
                    w_enq = 1'b1;
                    if (w_flag) begin
                        w_enq_eop    = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (r_word_cnt != WC_SAT) begin
                        w_word_cnt_next = r_word_cnt + 1'b1;
                        w_ovf           = (r_word_cnt == WC_MAX);
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Framing state register and word counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_word_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_word_cnt <= w_word_cnt_next;
        end
    end

    // Read tracking and skid buffer occupancy/head pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_head     <= 1'b0;
        end else begin
            r_inflight <= fifo_read_enable;
            case ({w_enq, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    // Skid buffer storage write; contents only matter while counted in r_occ.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_buf_data[w_wr_idx] <= fifo_read_data;
            r_buf_sop[w_wr_idx]  <= w_enq_sop;
            r_buf_eop[w_wr_idx]  <= w_enq_eop;
        end
    end

    // Statistics counters and single-cycle error pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_event_count    <= '0;
            r_dropped_count  <= '0;
            r_framing_error  <= 1'b0;
            r_overflow_error <= 1'b0;
        end else begin
            r_framing_error  <= w_drop;
            r_overflow_error <= w_ovf;
            if (w_drop) begin
                r_dropped_count <= sat_inc(r_dropped_count);
            end
            // An event is complete only once its footer leaves downstream.
            if (w_pop && r_buf_eop[r_head]) begin
                r_event_count <= sat_inc(r_event_count);
            end
        end
    end

endmodule
